memcpy_arbiter: RTL and testbench

MEMCPY_ARBITER -- requirements
Module: memcpy_arbiter

---
 rtl/memcpy_arbiter_if.sv | 48 ++++
 rtl/memcpy_arbiter.sv | 142 ++++++++++++++
 tb/tb_memcpy_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memcpy_arbiter_if.sv
// memcpy_arbiter_if
//   Bundles the two requester channels and the copy-engine channel of the
//   memcpy arbiter.
//   req0_* / req1_* : valid/addr/len from each requester, ready/done back to it
//   memcpy_*        : start/addr/len to the copy engine, done level back from it
//   busy/owner/timeout_err : arbiter status
//   Modports: slave  -- the arbiter itself
//             master -- requesters + engine (environment side)
interface memcpy_arbiter_if;
  logic        req0_valid;
  logic [63:0] req0_addr;
  logic [63:0] req0_len;
  logic        req0_ready;
  logic        req0_done;

  logic        req1_valid;
  logic [63:0] req1_addr;
  logic [63:0] req1_len;
  logic        req1_ready;
  logic        req1_done;

  logic        memcpy_start;
  logic [63:0] memcpy_addr;
  logic [63:0] memcpy_len;
  logic        memcpy_done;

  logic        busy;
  logic        owner;
  logic        timeout_err;

  modport slave (
    input  req0_valid, req0_addr, req0_len,
    input  req1_valid, req1_addr, req1_len,
    input  memcpy_done,
    output req0_ready, req0_done, req1_ready, req1_done,
    output memcpy_start, memcpy_addr, memcpy_len,
    output busy, owner, timeout_err
  );

  modport master (
    output req0_valid, req0_addr, req0_len,
    output req1_valid, req1_addr, req1_len,
    output memcpy_done,
    input  req0_ready, req0_done, req1_ready, req1_done,
    input  memcpy_start, memcpy_addr, memcpy_len,
    input  busy, owner, timeout_err
  );
endinterface

// File: rtl/memcpy_arbiter.sv
// memcpy_arbiter
//   Shares one copy engine between two requesters with round-robin
//   arbitration. A granted job is latched, the engine is kicked with a
//   one-cycle start pulse, and completion is reported back to the owning
//   requester with a one-cycle done pulse. Zero-length jobs complete without
//   touching the engine. An optional watchdog abandons a job whose engine
//   handshake never completes.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : memcpy_arbiter_if.slave (requester, engine and status signals)
// Parameters:
//   TIMEOUT : engine-wait limit in clk cycles, 0 disables the watchdog
module memcpy_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd0
) (
  input logic              clk,
  input logic              rst_n,
  memcpy_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT_LO,
    WAIT_HI,
    CMPL
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q;
  logic        last_q;     // requester served most recently
  logic [63:0] addr_q;
  logic [63:0] len_q;
  logic [31:0] wdog_q;

  logic        winner;
  logic [63:0] sel_addr;
  logic [63:0] sel_len;
  logic        wdog_hit;
  logic        timeout_err;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    timeout_err = 1'b0;

    // On a tie the requester that was not served last wins; a lone
    // request always wins.
    winner   = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
    sel_addr = owner_q ? bus.req1_addr : bus.req0_addr;
    sel_len  = owner_q ? bus.req1_len  : bus.req0_len;
    wdog_hit = (TIMEOUT != 32'd0) && (wdog_q == TIMEOUT - 32'd1);

    case (state_q)
      IDLE: begin
        // Never grant while the engine still reports a job in flight.
        if ((bus.req0_valid || bus.req1_valid) && bus.memcpy_done)
          state_d = GRANT;
      end
      GRANT: begin
        state_d = (sel_len == 64'd0) ? CMPL : START;
      end
      START: begin
        state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (wdog_hit) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else if (!bus.memcpy_done) begin
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (wdog_hit) begin
          timeout_err = 1'b1;
          state_d     = IDLE;
        end else if (bus.memcpy_done) begin
          state_d = CMPL;
        end
      end
      CMPL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 64'd0;
      len_q   <= 64'd0;
      wdog_q  <= 32'd0;
    end else begin
      state_q <= state_d;

      // Winner is fixed on the way into GRANT so the ready pulse and the
      // job capture refer to the same requester.
      if (state_q == IDLE && state_d == GRANT)
        owner_q <= winner;

      // Job parameters only ever change here, so they stay stable for the
      // whole engine handshake.
      if (state_q == GRANT) begin
        addr_q <= sel_addr;
        len_q  <= sel_len;
      end

      // A watchdog expiry skips this, leaving the failed requester first in
      // line on the next tie.
      if (state_q == CMPL)
        last_q <= owner_q;

      if (state_q == START)
        wdog_q <= 32'd0;
      else if (state_q == WAIT_LO || state_q == WAIT_HI)
        wdog_q <= wdog_q + 32'd1;
    end
  end

  assign bus.req0_ready   = (state_q == GRANT) && !owner_q;
  assign bus.req1_ready   = (state_q == GRANT) &&  owner_q;
  assign bus.req0_done    = ((state_q == CMPL) || timeout_err) && !owner_q;
  assign bus.req1_done    = ((state_q == CMPL) || timeout_err) &&  owner_q;
  assign bus.memcpy_start = (state_q == START);
  assign bus.memcpy_addr  = addr_q;
  assign bus.memcpy_len   = len_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.owner        = owner_q;
  assign bus.timeout_err  = timeout_err;

endmodule

// File: tb/tb_memcpy_arbiter.sv
// tb_memcpy_arbiter
//   Directed bench for memcpy_arbiter (TIMEOUT=100). A behavioural copy
//   engine drops memcpy_done 4 cycles after a start pulse and raises it 20
//   cycles later, unless it is switched off or held low.
module tb_memcpy_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic eng_done = 1'b1;   // engine model's done level
  logic eng_dead = 1'b0;   // engine ignores start pulses
  logic hold_lo  = 1'b0;   // forces done low (engine busy elsewhere)

  memcpy_arbiter_if bus ();

  memcpy_arbiter #(.TIMEOUT(32'd100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.memcpy_done = eng_done & ~hold_lo;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.memcpy_start && !eng_dead) begin
        repeat (4) @(negedge clk);
        eng_done = 1'b0;
        repeat (20) @(negedge clk);
        eng_done = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {bus.memcpy_start, bus.req0_ready, bus.req1_ready, bus.req0_done,
            bus.req1_done, bus.timeout_err, bus.busy, bus.owner};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = 64'd0; bus.req0_len = 64'd0;
    bus.req1_valid = 1'b0; bus.req1_addr = 64'd0; bus.req1_len = 64'd0;
    step; step;
    checks++;
    if (outs() !== 8'h00) begin
      errors++; $display("FAIL reset_outs: got %b expected 00000000", outs());
    end
    checks++;
    if (bus.memcpy_addr !== 64'd0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", bus.memcpy_addr);
    end
    checks++;
    if (bus.memcpy_len !== 64'd0) begin
      errors++; $display("FAIL reset_len: got %h expected 0", bus.memcpy_len);
    end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single;
    int g = -1, s = -1, d = -1;
    int n_rdy0 = 0, n_other = 0, n_start = 0, n_done0 = 0, hold_bad = 0;
    bit drop = 1'b0;
    bus.req0_addr = 64'h1000; bus.req0_len = 64'h200; bus.req0_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step;
      if (drop) begin
        bus.req0_valid = 1'b0; bus.req0_addr = 64'hDEAD; bus.req0_len = 64'h7;
        drop = 1'b0;
      end
      if (bus.req0_ready) begin n_rdy0++; g = c; drop = 1'b1; end
      if (bus.memcpy_start) begin n_start++; s = c; end
      if (bus.req0_done) begin n_done0++; d = c; end
      if (bus.req1_ready || bus.req1_done || bus.timeout_err) n_other++;
      if (s >= 0 && d < 0 &&
          (bus.memcpy_addr !== 64'h1000 || bus.memcpy_len !== 64'h200)) hold_bad++;
    end
    checks++;
    if (n_rdy0 != 1) begin errors++; $display("FAIL single_ready0_count: got %0d expected 1", n_rdy0); end
    checks++;
    if (n_start != 1) begin errors++; $display("FAIL single_start_count: got %0d expected 1", n_start); end
    checks++;
    if (s != g + 1) begin errors++; $display("FAIL single_start_cycle: got %0d expected %0d", s, g + 1); end
    checks++;
    if (n_done0 != 1) begin errors++; $display("FAIL single_done0_count: got %0d expected 1", n_done0); end
    checks++;
    if (d != s + 25) begin errors++; $display("FAIL single_done0_cycle: got %0d expected %0d", d, s + 25); end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL single_addr_len_hold: got %0d bad cycles expected 0", hold_bad); end
    checks++;
    if (n_other != 0) begin errors++; $display("FAIL single_other_pulses: got %0d expected 0", n_other); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_contention;
    int order [3] = '{-1, -1, -1};
    int n_rdy = 0, both_bad = 0, n_start = 0;
    bit drop = 1'b0;
    rst_n = 1'b0;
    bus.req0_addr = 64'h10; bus.req0_len = 64'd0; bus.req0_valid = 1'b1;
    bus.req1_addr = 64'h20; bus.req1_len = 64'd0; bus.req1_valid = 1'b1;
    step;
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step;
      if (drop) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; drop = 1'b0; end
      if ((bus.req0_ready && bus.req1_ready) || (bus.req0_done && bus.req1_done)) both_bad++;
      if (bus.memcpy_start) n_start++;
      if (bus.req0_ready || bus.req1_ready) begin
        if (n_rdy < 3) order[n_rdy] = bus.req1_ready ? 1 : 0;
        n_rdy++;
        if (n_rdy == 3) drop = 1'b1;
      end
    end
    checks++;
    if (order[0] != 0) begin errors++; $display("FAIL contention_grant0: got %0d expected 0", order[0]); end
    checks++;
    if (order[1] != 1) begin errors++; $display("FAIL contention_grant1: got %0d expected 1", order[1]); end
    checks++;
    if (order[2] != 0) begin errors++; $display("FAIL contention_grant2: got %0d expected 0", order[2]); end
    checks++;
    if (both_bad != 0) begin errors++; $display("FAIL contention_exclusive: got %0d expected 0", both_bad); end
    checks++;
    if (n_start != 0) begin errors++; $display("FAIL contention_no_start: got %0d expected 0", n_start); end
  endtask

  task automatic test_engine_busy;
    int n_rdy = 0, n_busy = 0;
    hold_lo = 1'b1;
    bus.req0_addr = 64'h55; bus.req0_len = 64'd0; bus.req0_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step;
      if (bus.req0_ready || bus.req1_ready) n_rdy++;
      if (bus.busy) n_busy++;
    end
    checks++;
    if (n_rdy != 0) begin errors++; $display("FAIL busy_engine_no_grant: got %0d expected 0", n_rdy); end
    checks++;
    if (n_busy != 0) begin errors++; $display("FAIL busy_engine_stay_idle: got %0d expected 0", n_busy); end
    hold_lo = 1'b0;
    step;
    checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL busy_engine_grant: got %b expected 1", bus.req0_ready); end
    bus.req0_valid = 1'b0;
    step;
    checks++;
    if (bus.req0_done !== 1'b1) begin errors++; $display("FAIL busy_engine_done0: got %b expected 1", bus.req0_done); end
    step;
  endtask

  task automatic test_zero_len;
    int r = -1, d = -1, n_r1 = 0, n_d1 = 0, n_bad = 0;
    bit drop = 1'b0;
    bus.req1_addr = 64'hABCD; bus.req1_len = 64'd0; bus.req1_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step;
      if (drop) begin bus.req1_valid = 1'b0; drop = 1'b0; end
      if (bus.req1_ready) begin n_r1++; r = c; drop = 1'b1; end
      if (bus.req1_done) begin n_d1++; d = c; end
      if (bus.memcpy_start || bus.req0_ready || bus.req0_done) n_bad++;
    end
    checks++;
    if (n_r1 != 1 || n_d1 != 1) begin errors++; $display("FAIL zero_len_pulses: got ready %0d done %0d expected 1 1", n_r1, n_d1); end
    checks++;
    if (d != r + 1) begin errors++; $display("FAIL zero_len_done_cycle: got %0d expected %0d", d, r + 1); end
    checks++;
    if (n_bad != 0) begin errors++; $display("FAIL zero_len_no_start: got %0d expected 0", n_bad); end
    checks++;
    if (bus.memcpy_addr !== 64'hABCD || bus.memcpy_len !== 64'd0) begin
      errors++; $display("FAIL zero_len_latch: got %h/%h expected abcd/0", bus.memcpy_addr, bus.memcpy_len);
    end
  endtask

  task automatic test_watchdog;
    int s = -1, t = -1, d = -1, n_to = 0, n_d0 = 0, busy_after = 0;
    bit drop = 1'b0;
    eng_dead = 1'b1;
    bus.req0_addr = 64'h2000; bus.req0_len = 64'h40; bus.req0_valid = 1'b1;
    for (int c = 0; c < 130; c++) begin
      step;
      if (drop) begin bus.req0_valid = 1'b0; drop = 1'b0; end
      if (bus.req0_ready) drop = 1'b1;
      if (bus.memcpy_start) s = c;
      if (bus.timeout_err) begin n_to++; t = c; end
      if (bus.req0_done) begin n_d0++; d = c; end
      if (t >= 0 && c > t && bus.busy) busy_after++;
    end
    checks++;
    if (n_to != 1) begin errors++; $display("FAIL watchdog_count: got %0d expected 1", n_to); end
    checks++;
    if (t != s + 100) begin errors++; $display("FAIL watchdog_cycle: got %0d expected %0d", t, s + 100); end
    checks++;
    if (n_d0 != 1 || d != t) begin errors++; $display("FAIL watchdog_done0: got %0d at %0d expected 1 at %0d", n_d0, d, t); end
    checks++;
    if (busy_after != 0) begin errors++; $display("FAIL watchdog_idle: got %0d busy cycles expected 0", busy_after); end
    // req1 was served last before the expiry, so req0 must still win a tie.
    bus.req0_len = 64'd0; bus.req1_len = 64'd0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    step;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++; $display("FAIL watchdog_keeps_priority: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step; step;
    eng_dead = 1'b0;
  endtask

  task automatic test_reset_mid_job;
    int lo_seen = 0, early = 0, spurious = 0, got = 0;
    bit drop = 1'b0, done_back = 1'b0;
    bus.req0_addr = 64'h3000; bus.req0_len = 64'h100; bus.req0_valid = 1'b1;
    for (int c = 0; c < 40 && lo_seen < 4; c++) begin
      step;
      if (drop) begin bus.req0_valid = 1'b0; drop = 1'b0; end
      if (bus.req0_ready) drop = 1'b1;
      if (bus.busy && !bus.memcpy_done) lo_seen++;
    end
    checks++;
    if (lo_seen != 4) begin errors++; $display("FAIL reset_mid_reach_wait_hi: got %0d expected 4", lo_seen); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'h00 || bus.memcpy_addr !== 64'd0 || bus.memcpy_len !== 64'd0) begin
      errors++; $display("FAIL reset_mid_outs: got %b/%h/%h expected 0/0/0", outs(), bus.memcpy_addr, bus.memcpy_len);
    end
    step; step;
    rst_n = 1'b1;
    bus.req1_addr = 64'h77; bus.req1_len = 64'd0; bus.req1_valid = 1'b1;
    for (int c = 0; c < 40 && got == 0; c++) begin
      step;
      if (!bus.memcpy_done && (bus.req0_ready || bus.req1_ready)) early++;
      if (!done_back && (bus.req0_done || bus.req1_done)) spurious++;
      if (bus.memcpy_done) done_back = 1'b1;
      if (bus.req1_ready) begin got = 1; bus.req1_valid = 1'b0; end
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d expected 0", spurious); end
    checks++;
    if (early != 0) begin errors++; $display("FAIL reset_mid_wait_engine: got %0d expected 0", early); end
    checks++;
    if (got != 1) begin errors++; $display("FAIL reset_mid_grant_after: got %0d expected 1", got); end
    step; step;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_engine_busy();
    test_zero_len();
    test_watchdog();
    test_reset_mid_job();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
